// File: rtl/sr_ff_checker.sv
// sr_ff_checker: cycle-accurate response checker for an active-low-reset SR flip-flop.
// It watches the flop's s/r stimulus and q/qb outputs, runs a one-cycle reference
// model of the flop and counts compare cycles and mismatches.
//
// Optional build macro: SR_CHK_STOP_ON_ERR_EN
//   defined   - the first mismatch is reported, then the checker locks into FAIL
//               and freezes all counters until rst is asserted.
//   undefined - FAIL is never entered; checking continues after errors.
//
// Pipeline: the flop updates q at edge N from s/r sampled at edge N. The checker
// compares that q at edge N+1 against the expectation it built at edge N, so the
// compare at an edge always happens before the reference update at that edge.

module sr_ff_checker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active-low
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qb,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic             undef,
    output logic             pass
);

`ifdef SR_CHK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_TRACK = 2'd0,
        ST_UNDEF = 2'd1,
        ST_FAIL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_exp_q;
    logic             r_err;
    logic             r_undef;
    logic             r_pass;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_chk_cnt;

    logic             w_cmp;
    logic             w_q_mis;
    logic             w_qb_mis;
    logic             w_mis;
    logic             w_set;
    logic             w_clr;
    logic             w_both;
    logic             w_exp_q_nxt;
    logic [CNT_W-1:0] w_err_cnt_nxt;
    logic [CNT_W-1:0] w_chk_cnt_nxt;
    logic             w_undef_nxt;
    logic             w_pass_nxt;

    // Decoded stimulus sampled at this edge.
    assign w_set  = s & ~r;
    assign w_clr  = ~s & r;
    assign w_both = s & r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_TRACK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Compare, reference-model update, next state and next output values.
    always_comb begin
        w_state_nxt   = r_state;
        w_cmp         = 1'b0;
        w_q_mis       = 1'b0;
        w_qb_mis      = 1'b0;
        w_mis         = 1'b0;
        w_exp_q_nxt   = r_exp_q;
        w_err_cnt_nxt = r_err_cnt;
        w_chk_cnt_nxt = r_chk_cnt;
        w_undef_nxt   = 1'b0;
        w_pass_nxt    = 1'b0;

        case (r_state)
            ST_TRACK: begin
                w_cmp   = 1'b1;
                w_q_mis = (q != r_exp_q);
            end
            ST_UNDEF: begin
                // Expected q is unknown here, only the complement is checked.
                w_cmp   = 1'b1;
            end
            default: begin
                w_cmp   = 1'b0;
            end
        endcase

        w_qb_mis = w_cmp & (qb == q);
        // A q and qb mismatch in the same cycle is a single error.
        w_mis    = w_q_mis | w_qb_mis;

        if (w_cmp) begin
            if (w_set) begin
                w_exp_q_nxt = 1'b1;
            end else if (w_clr) begin
                w_exp_q_nxt = 1'b0;
            end
        end

        case (r_state)
            ST_TRACK: begin
                if (STOP_ON_ERR && w_mis) begin
                    w_state_nxt = ST_FAIL;
                end else if (w_both) begin
                    w_state_nxt = ST_UNDEF;
                end
            end
            ST_UNDEF: begin
                if (STOP_ON_ERR && w_mis) begin
                    w_state_nxt = ST_FAIL;
                end else if (w_set || w_clr) begin
                    w_state_nxt = ST_TRACK;
                end
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_TRACK;
            end
        endcase

        // Saturating counters; both stay put outside compare cycles.
        if (w_cmp && (r_chk_cnt != CNT_MAX)) begin
            w_chk_cnt_nxt = r_chk_cnt + CNT_ONE;
        end
        if (w_mis && (r_err_cnt != CNT_MAX)) begin
            w_err_cnt_nxt = r_err_cnt + CNT_ONE;
        end

        w_undef_nxt = (w_state_nxt == ST_UNDEF);
        w_pass_nxt  = (w_chk_cnt_nxt != '0) && (w_err_cnt_nxt == '0);
    end

    // Reference model of the flop output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exp_q <= 1'b0;
        end else begin
            r_exp_q <= w_exp_q_nxt;
        end
    end

    // Registered status outputs and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err     <= 1'b0;
            r_undef   <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_chk_cnt <= '0;
        end else begin
            r_err     <= w_mis;
            r_undef   <= w_undef_nxt;
            r_pass    <= w_pass_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_chk_cnt <= w_chk_cnt_nxt;
        end
    end

    assign err     = r_err;
    assign undef   = r_undef;
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;
    assign chk_cnt = r_chk_cnt;

endmodule
